// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and access sequencer in front of the single-port data
// syncram. Requester 0 is the processor load/store port, requester 1 is the
// instruction-fetch or debug/loader port. One access is in flight at a time.
// Contention is resolved round-robin against the last granted requester.
//
// Every output is driven from a flop. Nothing combinational runs from req* to
// gnt* or mem_*.
//
// Access timing, counted from the clock edge that samples req:
//   write : cycle 1 = gnt + write strobe. The next request can be sampled at
//           the end of cycle 2.
//   read  : cycle 1 = gnt. mem_oe is held for MEM_LAT+1 cycles. rdata and
//           rvalid appear in cycle MEM_LAT+2.
//
// Optional feature (macro DMEM_ARB_LOCK_EN):
//   Adds the inputs lock0 and lock1, which are sampled with the winning req.
//   A locked owner keeps exclusive access until it is granted an access with
//   lock=0. While the lock is held, last_owner does not change.
//
// Parameters:
//   MEM_LAT : syncram read latency, 1..7 cycles
//   AW      : address width
//   DW      : data width
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req0/we0/addr0/wdata0       requester 0 command, held until gnt0
//   gnt0, rvalid0               requester 0 accept / read-data-valid pulses
//   req1/we1/addr1/wdata1       requester 1 command, held until gnt1
//   gnt1, rvalid1               requester 1 accept / read-data-valid pulses
//   lock0, lock1                bus lock requests (DMEM_ARB_LOCK_EN only)
//   rdata                       shared read data, held until the next read ends
//   mem_cs/oe/we/addr/din       syncram control, address and write data
//   mem_dout                    syncram read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic [DW-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t        state, state_nxt;
    logic [2:0]    lat_cnt, lat_cnt_nxt;
    logic          owner, owner_nxt;
    logic          last_owner, last_owner_nxt;
    logic          cmd_we, cmd_we_nxt;
    logic [AW-1:0] cmd_addr_nxt;
    logic [DW-1:0] cmd_wdata_nxt;
    logic [DW-1:0] rdata_nxt;

    logic          cand0, cand1;
    logic          grant;
    logic          win;
    logic          rd_done;

    logic          gnt0_nxt, gnt1_nxt;
    logic          rvalid0_nxt, rvalid1_nxt;
    logic          mem_cs_nxt, mem_oe_nxt, mem_we_nxt;

`ifdef DMEM_ARB_LOCK_EN
    logic          locked, locked_nxt;
`endif

    // Arbitration. A requester is a candidate only while the FSM is idle.
    // When both requesters want the bus, the one that did not own the last
    // access wins. A held lock masks out the requester that does not own it.
    always_comb begin
        cand0 = req0;
        cand1 = req1;
`ifdef DMEM_ARB_LOCK_EN
        if (locked) begin
            if (owner) begin
                cand0 = 1'b0;
            end else begin
                cand1 = 1'b0;
            end
        end
`endif
        grant = (state == IDLE) && (cand0 || cand1);
        win   = cand1 && (!cand0 || !last_owner);
    end

    // The last RDWAIT cycle: the syncram output is captured at its closing edge.
    assign rd_done = (state == RDWAIT) && (lat_cnt == 3'd1);

    // State register. The command registers drive mem_addr/mem_din directly,
    // so the address and write data stay stable for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cmd_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            rdata      <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            locked     <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cmd_we     <= cmd_we_nxt;
            mem_addr   <= cmd_addr_nxt;
            mem_din    <= cmd_wdata_nxt;
            rdata      <= rdata_nxt;
            gnt0       <= gnt0_nxt;
            gnt1       <= gnt1_nxt;
            rvalid0    <= rvalid0_nxt;
            rvalid1    <= rvalid1_nxt;
            mem_cs     <= mem_cs_nxt;
            mem_oe     <= mem_oe_nxt;
            mem_we     <= mem_we_nxt;
`ifdef DMEM_ARB_LOCK_EN
            locked     <= locked_nxt;
`endif
        end
    end

    // Next-state and command/datapath update.
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cmd_we_nxt     = cmd_we;
        cmd_addr_nxt   = mem_addr;
        cmd_wdata_nxt  = mem_din;
        rdata_nxt      = rdata;
`ifdef DMEM_ARB_LOCK_EN
        locked_nxt     = locked;
`endif
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = win;
                    cmd_we_nxt    = win ? we1 : we0;
                    cmd_addr_nxt  = win ? addr1 : addr0;
                    cmd_wdata_nxt = win ? wdata1 : wdata0;
`ifdef DMEM_ARB_LOCK_EN
                    // The grant that takes a lock still moves last_owner.
                    // Grants made under an existing lock leave it alone.
                    if (!locked) begin
                        last_owner_nxt = win;
                    end
                    locked_nxt = win ? lock1 : lock0;
`else
                    last_owner_nxt = win;
`endif
                end
            end
            ACCESS: begin
                if (cmd_we) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt   = RDWAIT;
                    lat_cnt_nxt = LAT_INIT;
                end
            end
            RDWAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_nxt = IDLE;
                    rdata_nxt = mem_dout;
                end else begin
                    lat_cnt_nxt = lat_cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode. Pin values are derived from the state being entered, so
    // the registered outputs line up with that state.
    always_comb begin
        gnt0_nxt    = grant && !win;
        gnt1_nxt    = grant && win;
        rvalid0_nxt = rd_done && !owner;
        rvalid1_nxt = rd_done && owner;
        mem_cs_nxt  = (state_nxt != IDLE);
        mem_we_nxt  = (state_nxt == ACCESS) && cmd_we_nxt;
        mem_oe_nxt  = ((state_nxt == ACCESS) && !cmd_we_nxt) ||
                      (state_nxt == RDWAIT);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed and randomized bench for dmem_arbiter.
// Main instance: MEM_LAT=1, with a 256-word syncram model.
// Second instance: MEM_LAT=3. Its mem_dout carries a cycle stamp, which shows
// exactly which cycle the read data was taken from.
// The reference model works at the transaction level: a winner rule, a
// shadow memory, and the fixed gnt/oe/rvalid cycle offsets of each access.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    logic        b_req0, b_we0, b_req1, b_we1;
    logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
    logic        b_gnt0, b_rvalid0, b_gnt1, b_rvalid1;
    logic [31:0] b_rdata;
    logic        b_mem_cs, b_mem_oe, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;

`ifdef DMEM_ARB_LOCK_EN
    logic        lock0, lock1, b_lock0, b_lock1;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference state
    logic [31:0] ref_mem [256];
    bit          m_last;
`ifdef DMEM_ARB_LOCK_EN
    bit          m_locked;
    bit          m_lock_owner;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rdata(rdata),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    dmem_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0(b_lock0), .lock1(b_lock1),
`endif
        .rdata(b_rdata),
        .mem_cs(b_mem_cs), .mem_oe(b_mem_oe), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    // Power-on contents of the syncram; 0x10 holds a recognisable word.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'h3C};
    endfunction

    // Syncram model for the main instance.
    logic [31:0] wmem [256];
    bit          written [256];
    logic [7:0]  mem_idx;
    assign mem_idx  = mem_addr[7:0];
    assign mem_dout = mem_oe ? (written[mem_idx] ? wmem[mem_idx] : init_val(mem_idx))
                             : 32'h0;
    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            wmem[mem_idx]    <= mem_din;
            written[mem_idx] <= 1'b1;
        end
    end

    // Cycle stamp on dut_b's read data.
    logic [15:0] cyc = 16'd0;
    always @(posedge clk) cyc <= cyc + 16'd1;
    assign b_mem_dout = b_mem_oe ? {16'hC0DE, cyc} : 32'h0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, ".gnt0"}, gnt0, 1'b0);
        chk1({tag, ".gnt1"}, gnt1, 1'b0);
        chk1({tag, ".rvalid0"}, rvalid0, 1'b0);
        chk1({tag, ".rvalid1"}, rvalid1, 1'b0);
        chk32({tag, ".rdata"}, rdata, 32'h0);
        chk1({tag, ".mem_cs"}, mem_cs, 1'b0);
        chk1({tag, ".mem_oe"}, mem_oe, 1'b0);
        chk1({tag, ".mem_we"}, mem_we, 1'b0);
        chk32({tag, ".mem_addr"}, mem_addr, 32'h0);
        chk32({tag, ".mem_din"}, mem_din, 32'h0);
    endtask

    // Winner rule: a single requester wins outright. With both requesting, the
    // one that is not the last owner wins. A lock excludes the other requester.
    function automatic bit pick(input bit r0, input bit r1);
        bit c0, c1;
        c0 = r0;
        c1 = r1;
`ifdef DMEM_ARB_LOCK_EN
        if (m_locked) begin
            if (m_lock_owner) c0 = 1'b0;
            else              c1 = 1'b0;
        end
`endif
        if (c0 && c1) return !m_last;
        return c1;
    endfunction

    // One arbitration round, entered and left at a negedge with the DUT idle.
    task automatic round(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input bit keep);
        bit          w;
        bit          wr;
        logic [31:0] a, d;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        w  = pick(r0, r1);
        wr = w ? w1 : w0;
        a  = w ? a1 : a0;
        d  = w ? d1 : d0;
`ifdef DMEM_ARB_LOCK_EN
        if (!m_locked) m_last = w;
        m_locked     = w ? lock1 : lock0;
        m_lock_owner = w;
`else
        m_last = w;
`endif
        @(negedge clk);
        chk1("c1.gnt0", gnt0, !w);
        chk1("c1.gnt1", gnt1, w);
        chk1("c1.mem_cs", mem_cs, 1'b1);
        chk1("c1.mem_we", mem_we, wr);
        chk1("c1.mem_oe", mem_oe, !wr);
        chk32("c1.mem_addr", mem_addr, a);
        if (wr) chk32("c1.mem_din", mem_din, d);
        if (!keep) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        if (wr) begin
            ref_mem[a[7:0]] = d;
            @(negedge clk);
            chk1("wr.c2.mem_we", mem_we, 1'b0);
            chk1("wr.c2.mem_cs", mem_cs, 1'b0);
            chk1("wr.c2.gnt", gnt0 | gnt1, 1'b0);
            chk1("wr.c2.rvalid", rvalid0 | rvalid1, 1'b0);
        end else begin
            for (int k = 2; k <= LAT + 2; k++) begin
                @(negedge clk);
                chk1("rd.mem_oe", mem_oe, k <= LAT + 1);
                chk1("rd.rvalid0", rvalid0, (k == LAT + 2) && !w);
                chk1("rd.rvalid1", rvalid1, (k == LAT + 2) && w);
                chk1("rd.no_gnt", gnt0 | gnt1, 1'b0);
            end
            chk32("rd.rdata", rdata, ref_mem[a[7:0]]);
        end
    endtask

    initial begin
        logic [31:0] ca0, ca1;
        logic [31:0] stamp;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        m_last = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        m_locked = 1'b0; m_lock_owner = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; b_lock0 = 1'b0; b_lock1 = 1'b0;
`endif
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
        b_req1 = 0; b_we1 = 0; b_addr1 = 0; b_wdata1 = 0;
        rst_n = 1'b0;

        // Reset: every output is zero, and stays zero when nothing is requested.
        repeat (2) @(negedge clk);
        check_zero("rst");
        chk1("rst.b_mem_oe", b_mem_oe, 1'b0);
        chk1("rst.b_rvalid0", b_rvalid0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("idle");

        // Both requesters read continuously. Grants must alternate, starting with 0.
        ca0 = 32'h40; ca1 = 32'h80;
        for (int i = 0; i < 6; i++) begin
            round(1, 1, 0, 0, ca0, ca1, 32'h0, 32'h0, 1);
            chk1("rr.alternate", m_last, (i % 2) == 1);
            if (m_last) ca1 = 32'($urandom_range(0, 255));
            else        ca0 = 32'($urandom_range(0, 255));
        end
        req0 = 1'b0; req1 = 1'b0;

        // Requester 0 reads 0x10.
        round(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0);
        chk32("dead.rdata", rdata, 32'hDEADBEEF);

        // A write by requester 0 is read back by requester 1. rdata survives a later write.
        round(1, 0, 1, 0, 32'h20, 32'h0, 32'h12345678, 32'h0, 0);
        round(0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 32'h0, 0);
        chk32("wr_rd.rdata", rdata, 32'h12345678);
        round(0, 1, 1, 1, 32'h0, 32'h21, 32'h0, 32'hCAFEF00D, 0);
        chk32("rdata_hold", rdata, 32'h12345678);

        // Randomized request patterns
        for (int i = 0; i < 40; i++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            round(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                  $urandom, $urandom, 0);
        end

        // Reset asserted in the RDWAIT cycle of a requester 1 read.
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h30;
        @(negedge clk);
        chk1("rstmid.gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("rstmid");
        m_last = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        m_locked = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rstmid.no_rvalid1", rvalid1, 1'b0);
            chk1("rstmid.no_cs", mem_cs, 1'b0);
        end
        round(1, 1, 0, 0, 32'h10, 32'h20, 32'h0, 32'h0, 0);
        chk1("rstmid.next_owner0", m_last, 1'b0);

        // MEM_LAT=3 instance: mem_oe is held for 4 cycles and rvalid arrives in cycle 5.
        // rdata must be the stamp from the last hold cycle.
        stamp = 32'h0;
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 32'h44;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk1("lat3.gnt0", b_gnt0, 1'b1);
                b_req0 = 1'b0;
            end
            if (k == 4) stamp = {16'hC0DE, cyc};
            chk1("lat3.mem_oe", b_mem_oe, k <= 4);
            chk1("lat3.rvalid0", b_rvalid0, k == 5);
            chk1("lat3.rvalid1", b_rvalid1, 1'b0);
        end
        chk32("lat3.rdata", b_rdata, stamp);

`ifdef DMEM_ARB_LOCK_EN
        // Requester 0 locks for two accesses and releases on the third, while
        // requester 1 stays pending. Expect gnt0 three times, then gnt1.
        round(0, 1, 1, 1, 32'h0, 32'h50, 32'h0, 32'h1, 0);
        lock0 = 1'b1;
        round(1, 1, 1, 1, 32'h60, 32'h50, 32'hA, 32'hB, 1);
        chk1("lock.g1", m_last, 1'b0);
        round(1, 1, 1, 1, 32'h60, 32'h50, 32'hA, 32'hB, 1);
        lock0 = 1'b0;
        round(1, 1, 1, 1, 32'h60, 32'h50, 32'hA, 32'hB, 1);
        round(1, 1, 1, 1, 32'h60, 32'h50, 32'hA, 32'hB, 1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data syncram (cs/oe/we/addr/din/dout).
- Requester 0 is the load/store port of the processor; requester 1 is the instruction-fetch or debug/loader port.
- Grants one access at a time, round-robin on contention.
- Drives the syncram control pins and returns read data with a valid pulse to the owning requester.

Parameters:
- MEM_LAT, 1: syncram read latency in cycles (1..7); the number of cycles oe/cs are held before dout is sampled.
- AW, 32: address width passed to syncram.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request; held with stable we0/addr0/wdata0 until gnt0.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  one-cycle pulse: requester 0 command accepted.
- rvalid0  out  1  one-cycle pulse: rdata valid for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as above for requester 1.
- rdata  out  DW  shared read-data register.
- mem_cs  out  1  syncram chip select.
- mem_oe  out  1  syncram output enable.
- mem_we  out  1  syncram write enable.
- mem_addr  out  AW  syncram address.
- mem_din  out  DW  syncram write data.
- mem_dout  in  DW  syncram read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_owner=1.
  - All outputs 0: gnt*, rvalid*, rdata, mem_cs, mem_oe, mem_we, mem_addr, mem_din.
  - An in-flight access is dropped; no rvalid is issued after reset release.
- All outputs are registered; no combinational path from req to mem_* or gnt.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - On a clock edge with any req, latch the winner's we/addr/wdata into the command registers and set owner.
  - Pulse the owner's gnt in the following cycle and go to ACCESS.
  - No req: stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester != last_owner wins.
  - last_owner updates to owner at grant.
- ACCESS (exactly 1 cycle): mem_cs=1, mem_addr=cmd addr, mem_din=cmd wdata, gnt_owner=1.
  - Write: mem_we=1, mem_oe=0; next state IDLE. No rvalid for writes.
  - Read: mem_we=0, mem_oe=1; load latency counter with MEM_LAT; next state RDWAIT.
- RDWAIT:
  - mem_cs=1, mem_oe=1, mem_we=0, address held.
  - Counter decrements each cycle. On the cycle it reaches 1, rdata<=mem_dout at the edge and rvalid_owner pulses the next cycle.
  - Next state IDLE.
- Latency:
  - Write: req high before edge E0, gnt and write strobe in cycle E0..E1, memory written at E1.
  - Read: gnt at cycle 1, rvalid at cycle MEM_LAT+2 after req is sampled.
  - Read throughput: one access per MEM_LAT+2 cycles. Write throughput: one access per 2 cycles.
- rdata holds its value until the next read completes; it does not clear on writes.
- IDLE may issue a new grant in the same cycle rvalid is high (back-to-back overlap permitted).
- A req dropped before gnt: the request is withdrawn. If already latched, the access still completes.
- Requesters must not change addr/we/wdata while req=1 and gnt=0.
- Counter width: 3 bits; MEM_LAT=0 is illegal.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Macro defined:
  - Adds inputs lock0 and lock1 (1 bit each), sampled with the winning req.
  - If the owner's lock=1 at grant, the next grant goes only to that owner; the other requester is ignored even if pending.
  - The lock releases after a granted access with lock=0.
  - last_owner does not update while locked.
  - Reset clears the lock.
- Macro undefined: no lock ports; pure round-robin as above.

Test Plan:
- Reset with MEM_LAT=1: all outputs 0 until a req arrives. req0 read addr 0x10 (mem holds 0xDEADBEEF) -> gnt0 at cycle 1, mem_oe=1 for cycles 1-2, rvalid0 at cycle 3 with rdata=0xDEADBEEF; gnt1/rvalid1 stay 0.
- req0 write addr 0x20 data 0x12345678, then req1 read 0x20 -> mem_we pulses one cycle with mem_din=0x12345678; rvalid1 returns rdata=0x12345678.
- req0 and req1 held high continuously with reads -> grants alternate 0,1,0,1 (first grant to 0); each rvalid matches its owner; no double grants.
- rst_n pulled low during RDWAIT of a req1 read -> all outputs 0 immediately; after release no rvalid1; next request arbitrates from last_owner=1.
- MEM_LAT=3 read -> mem_oe held 4 cycles, rvalid at cycle 5, rdata = mem_dout sampled on the last hold cycle.
- With DMEM_ARB_LOCK_EN: req0 with lock0=1 for two accesses and lock0=0 on the third, with req1 pending throughout -> three consecutive gnt0, then gnt1.
